// File: rtl/router_out_arbiter_if.sv
// Link between the router's three output FIFOs, the arbiter and the downstream byte sink.
// The master side is the arbiter; the slave side is the FIFO/sink environment.
interface router_out_arbiter_if;
  logic       empty_0;
  logic       empty_1;
  logic       empty_2;
  logic [7:0] data_out_0;
  logic [7:0] data_out_1;
  logic [7:0] data_out_2;
  logic       out_ready;
  logic       read_enb_0;
  logic       read_enb_1;
  logic       read_enb_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] grant;
  logic       busy;

  modport master (
    input  empty_0, empty_1, empty_2,
    input  data_out_0, data_out_1, data_out_2,
    input  out_ready,
    output read_enb_0, read_enb_1, read_enb_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output out_data, out_valid, out_sop, out_eop,
    output grant, busy
  );

  modport slave (
    output empty_0, empty_1, empty_2,
    output data_out_0, data_out_1, data_out_2,
    output out_ready,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  out_data, out_valid, out_sop, out_eop,
    input  grant, busy
  );
endinterface

// File: rtl/router_out_arbiter.sv
// Packet-granular round-robin arbiter: serves one of three output FIFOs at a time,
// fetching each byte (FETCH -> CAPTURE -> SEND) and offering it downstream with
// valid/ready. A downstream stall of TIMEOUT cycles drops the packet and pulses
// the served port's soft reset.
module router_out_arbiter #(
  parameter int unsigned TIMEOUT = 30
) (
  input logic                  clock,
  input logic                  reset,
  router_out_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SEND} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] grant_q;
  logic [1:0] ptr_q;
  logic       first_q;
  logic [6:0] left_q;
  logic [7:0] hold_q;
  logic [7:0] stall_cnt_q;
  logic [2:0] soft_reset_q;

  logic [2:0] empty_vec;
  logic [2:0] eligible;
  logic [7:0] data_sel;
  logic       empty_sel;
  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] pick;
  logic       pick_valid;
  logic       eop;
  logic       timeout_hit;
  logic [2:0] read_vec;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty_vec   = {bus.empty_2, bus.empty_1, bus.empty_0};
  // A port being soft-reset this cycle is not offered a new grant.
  assign eligible    = ~empty_vec & ~soft_reset_q;
  assign eop         = !first_q && (left_q == 7'd0);
  assign timeout_hit = !bus.out_ready && (stall_cnt_q == 8'(TIMEOUT - 1));

  // Select the granted FIFO's read data and empty flag.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    data_sel  = bus.data_out_0;
    empty_sel = bus.empty_0;
    case (grant_q)
      2'd1: begin
        data_sel  = bus.data_out_1;
        empty_sel = bus.empty_1;
      end
      2'd2: begin
        data_sel  = bus.data_out_2;
        empty_sel = bus.empty_2;
      end
      default: ;
    endcase
  end

  // Round-robin search: first eligible port after the last one served, with wrap.
  always_comb begin
    cand0      = next_port(ptr_q);
    cand1      = next_port(cand0);
    cand2      = next_port(cand1);
    pick       = cand0;
    pick_valid = 1'b1;
    if (eligible[cand0])      pick = cand0;
    else if (eligible[cand1]) pick = cand1;
    else if (eligible[cand2]) pick = cand2;
    else                      pick_valid = 1'b0;
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = FETCH;
      FETCH:   if (!empty_sel) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND: begin
        if (bus.out_ready) state_nxt = eop ? IDLE : FETCH;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, byte holding, length tracking, stall counting and soft-reset pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q      <= 2'd0;
      ptr_q        <= 2'd2;
      first_q      <= 1'b0;
      left_q       <= 7'd0;
      hold_q       <= 8'd0;
      stall_cnt_q  <= 8'd0;
      soft_reset_q <= 3'b000;
    end else begin
      soft_reset_q <= 3'b000;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick;
            first_q <= 1'b1;
          end
        end
        CAPTURE: begin
          hold_q      <= data_sel;
          // Header carries len in [7:2]; bytes after it are len payload + 1 parity.
          left_q      <= first_q ? ({1'b0, data_sel[7:2]} + 7'd1) : (left_q - 7'd1);
          stall_cnt_q <= 8'd0;
        end
        SEND: begin
          if (bus.out_ready) begin
            first_q     <= 1'b0;
            stall_cnt_q <= 8'd0;
            if (eop) ptr_q <= grant_q;
          end else if (timeout_hit) begin
            ptr_q                 <= grant_q;
            soft_reset_q[grant_q] <= 1'b1;
            stall_cnt_q           <= 8'd0;
          end else begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    read_vec = 3'b000;
    if (state == FETCH && !empty_sel) read_vec = 3'b001 << grant_q;
  end

  assign bus.read_enb_0   = read_vec[0];
  assign bus.read_enb_1   = read_vec[1];
  assign bus.read_enb_2   = read_vec[2];
  assign bus.soft_reset_0 = soft_reset_q[0];
  assign bus.soft_reset_1 = soft_reset_q[1];
  assign bus.soft_reset_2 = soft_reset_q[2];
  assign bus.out_valid    = (state == SEND);
  assign bus.out_data     = (state == SEND) ? hold_q : 8'd0;
  assign bus.out_sop      = (state == SEND) && first_q;
  assign bus.out_eop      = (state == SEND) && eop;
  assign bus.grant        = grant_q;
  assign bus.busy         = (state != IDLE);

endmodule
